// File: rtl/stream_word_packer.sv
// stream_word_packer
//   Collects a serial bit stream into WIDTH-bit words, MSB first, and emits
//   a word with its valid-bit count as a single-cycle strobe. A word is emitted
//   when it fills, when the last bit of a packet arrives, or on flush. A flush
//   with no bits held does nothing. Partial words are zero-filled in the LSBs.
//   The block never applies backpressure.
//
// Ports
//   clk_i       rising-edge clock
//   arst_n_i    asynchronous active-low reset, drops any word in progress
//   data_i      serial data bit
//   data_val_i  qualifies data_i and last_i
//   last_i      current bit is the final bit of a packet
//   flush_i     emit any partially filled word
//   data_o      packed word, held stable between strobes
//   data_val_o  one-cycle strobe qualifying data_o / data_len_o
//   data_len_o  number of valid bits in data_o (1..WIDTH)
module stream_word_packer #(
   parameter int WIDTH = 16
) (
   input  logic                   clk_i,
   input  logic                   arst_n_i,
   input  logic                   data_i,
   input  logic                   data_val_i,
   input  logic                   last_i,
   input  logic                   flush_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   data_val_o,
   output logic [$clog2(WIDTH):0] data_len_o
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic {EMPTY, FILL} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_inc, cnt_nxt;
   logic [WIDTH-1:0] acc, acc_inc, acc_nxt;
   logic             emit;

   // Next-state and datapath. acc_inc / cnt_inc already include the current
   // bit, so emission on a full word, last or flush+data all see that bit.
   always_comb begin
      cnt_inc   = cnt + {{(CW-1){1'b0}}, data_val_i};
      acc_inc   = acc;
      emit      = 1'b0;
      state_nxt = state;
      cnt_nxt   = cnt_inc;
      acc_nxt   = acc_inc;

      // Bit k of the word lands at position WIDTH-1-k; cnt < WIDTH here.
      if (data_val_i && data_i)
         acc_inc = acc | (TOP_BIT >> cnt);
      acc_nxt = acc_inc;

      if (data_val_i)
         emit = (cnt_inc == CW'(WIDTH)) || last_i || flush_i;
      else
         emit = flush_i && (state == FILL);

      if (emit) begin
         // Clearing acc here makes the next partial word zero-filled.
         state_nxt = EMPTY;
         cnt_nxt   = '0;
         acc_nxt   = '0;
      end else if (data_val_i) begin
         state_nxt = FILL;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) state <= EMPTY;
      else           state <= state_nxt;
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         cnt <= '0;
         acc <= '0;
      end else begin
         cnt <= cnt_nxt;
         acc <= acc_nxt;
      end
   end

   // Output register: strobe for one cycle, word and length hold otherwise.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         data_val_o <= 1'b0;
         data_o     <= '0;
         data_len_o <= '0;
      end else begin
         data_val_o <= emit;
         if (emit) begin
            data_o     <= acc_inc;
            data_len_o <= cnt_inc;
         end
      end
   end

endmodule
